// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_arb_pkg                                                              |
// | Shared types and sizes for the Wishbone round-robin arbiter.            |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
package wb_arb_pkg;

  localparam int NMASTERS = 4;
  localparam int ID_W     = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_priority_pick                                                        |
// | Rotating priority picker: first requester strictly after the last ID.   |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module rr_priority_pick
  import wb_arb_pkg::*;
(
  input  logic [NMASTERS-1:0] i_req,
  input  logic [ID_W-1:0]     i_last_id,
  output logic [NMASTERS-1:0] o_grant,
  output logic [ID_W-1:0]     o_grant_id,
  output logic                o_valid
);

  logic [ID_W-1:0] w_idx;

  // Search order last+1, last+2, ... with the 2-bit sum wrapping 4 back to 1.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_valid    = 1'b0;
    w_idx      = '0;
    for (int i = 1; i <= NMASTERS; i++) begin
      w_idx = i_last_id + ID_W'(i);
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant_id     = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wb_rr_arbiter                                                           |
// | Four-master Wishbone arbiter: round-robin, cyc-locked, slave watchdog.  |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int FIRST_PRIO = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic        wb1_cyc_i,
  input  logic        wb1_stb_i,
  input  logic        wb1_we_i,
  input  logic [3:0]  wb1_sel_i,
  input  logic [31:0] wb1_adr_i,
  input  logic [31:0] wb1_dat_i,
  output logic [31:0] wb1_dat_o,
  output logic        wb1_ack_o,
  output logic        wb1_err_o,

  input  logic        wb2_cyc_i,
  input  logic        wb2_stb_i,
  input  logic        wb2_we_i,
  input  logic [3:0]  wb2_sel_i,
  input  logic [31:0] wb2_adr_i,
  input  logic [31:0] wb2_dat_i,
  output logic [31:0] wb2_dat_o,
  output logic        wb2_ack_o,
  output logic        wb2_err_o,

  input  logic        wb3_cyc_i,
  input  logic        wb3_stb_i,
  input  logic        wb3_we_i,
  input  logic [3:0]  wb3_sel_i,
  input  logic [31:0] wb3_adr_i,
  input  logic [31:0] wb3_dat_i,
  output logic [31:0] wb3_dat_o,
  output logic        wb3_ack_o,
  output logic        wb3_err_o,

  input  logic        wb4_cyc_i,
  input  logic        wb4_stb_i,
  input  logic        wb4_we_i,
  input  logic [3:0]  wb4_sel_i,
  input  logic [31:0] wb4_adr_i,
  input  logic [31:0] wb4_dat_i,
  output logic [31:0] wb4_dat_o,
  output logic        wb4_ack_o,
  output logic        wb4_err_o,

  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,

  output logic [3:0]  grant_o
);

  // Reset "last" is FIRST_PRIO-1 in 1-based terms, 0 meaning master 4.
  localparam logic [ID_W-1:0]  c_reset_last = ID_W'((FIRST_PRIO + 2) % NMASTERS);
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);

  logic [NMASTERS-1:0] w_cyc, w_stb, w_we;
  logic [3:0]          w_sel [NMASTERS];
  logic [31:0]         w_adr [NMASTERS];
  logic [31:0]         w_dat [NMASTERS];
  logic [NMASTERS-1:0] w_ack, w_err;

  assign w_cyc = {wb4_cyc_i, wb3_cyc_i, wb2_cyc_i, wb1_cyc_i};
  assign w_stb = {wb4_stb_i, wb3_stb_i, wb2_stb_i, wb1_stb_i};
  assign w_we  = {wb4_we_i,  wb3_we_i,  wb2_we_i,  wb1_we_i};
  assign w_sel[0] = wb1_sel_i;
  assign w_sel[1] = wb2_sel_i;
  assign w_sel[2] = wb3_sel_i;
  assign w_sel[3] = wb4_sel_i;
  assign w_adr[0] = wb1_adr_i;
  assign w_adr[1] = wb2_adr_i;
  assign w_adr[2] = wb3_adr_i;
  assign w_adr[3] = wb4_adr_i;
  assign w_dat[0] = wb1_dat_i;
  assign w_dat[1] = wb2_dat_i;
  assign w_dat[2] = wb3_dat_i;
  assign w_dat[3] = wb4_dat_i;

  assign {wb4_ack_o, wb3_ack_o, wb2_ack_o, wb1_ack_o} = w_ack;
  assign {wb4_err_o, wb3_err_o, wb2_err_o, wb1_err_o} = w_err;
  assign wb1_dat_o = wbs_dat_i;
  assign wb2_dat_o = wbs_dat_i;
  assign wb3_dat_o = wbs_dat_i;
  assign wb4_dat_o = wbs_dat_i;

  arb_state_t          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_owner, r_last;
  logic [NMASTERS-1:0] r_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_pend;

  logic [NMASTERS-1:0] w_pick_grant;
  logic [ID_W-1:0]     w_pick_id;
  logic                w_pick_valid;
  logic                w_own_cyc, w_own_stb;

  assign w_own_cyc = w_cyc[r_owner];
  assign w_own_stb = w_stb[r_owner];

  rr_priority_pick u_pick (
    .i_req      (w_cyc),
    .i_last_id  (r_last),
    .o_grant    (w_pick_grant),
    .o_grant_id (w_pick_id),
    .o_valid    (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = BUSY;
      BUSY: begin
        if (!w_own_cyc)
          w_state_nxt = IDLE;
        else if (w_own_stb && !wbs_ack_i && (r_cnt == c_timeout))
          w_state_nxt = ABORT;
      end
      ABORT:   if (!w_own_cyc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= c_reset_last;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_pend <= (r_state == BUSY) && (w_state_nxt == ABORT);
      if (r_state == IDLE && w_pick_valid) begin
        r_owner <= w_pick_id;
        r_last  <= w_pick_id;
        r_grant <= w_pick_grant;
      end
      // Watchdog only measures unacknowledged strobes inside a live tenure.
      if (r_state == BUSY && w_own_stb && !wbs_ack_i)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    w_ack     = '0;
    w_err     = '0;
    case (r_state)
      BUSY: begin
        wbs_cyc_o      = w_own_cyc;
        wbs_stb_o      = w_own_stb;
        wbs_we_o       = w_we[r_owner];
        wbs_sel_o      = w_sel[r_owner];
        wbs_adr_o      = w_adr[r_owner];
        wbs_dat_o      = w_dat[r_owner];
        w_ack[r_owner] = wbs_ack_i;
      end
      ABORT: begin
        wbs_we_o       = w_we[r_owner];
        wbs_sel_o      = w_sel[r_owner];
        wbs_adr_o      = w_adr[r_owner];
        wbs_dat_o      = w_dat[r_owner];
        w_err[r_owner] = r_err_pend;
      end
      default: ;
    endcase
  end

  assign grant_o = (r_state == IDLE) ? '0 : r_grant;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_wb_rr_arbiter                                                        |
// | Scenario bench for wb_rr_arbiter with a queue of expected outcomes.     |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module tb_wb_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel [4];
  logic [31:0] m_adr [4];
  logic [31:0] m_dat [4];
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] d1, d2, d3, d4;
  logic        a1, a2, a3, a4, e1, e2, e3, e4;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o;
  logic [3:0]  grant;

  logic [3:0] ack_v, err_v;
  assign ack_v = {a4, a3, a2, a1};
  assign err_v = {e4, e3, e2, e1};

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  wb_rr_arbiter #(.TIMEOUT(4), .FIRST_PRIO(1)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb1_cyc_i(m_cyc[0]), .wb1_stb_i(m_stb[0]), .wb1_we_i(m_we[0]), .wb1_sel_i(m_sel[0]),
    .wb1_adr_i(m_adr[0]), .wb1_dat_i(m_dat[0]), .wb1_dat_o(d1), .wb1_ack_o(a1), .wb1_err_o(e1),
    .wb2_cyc_i(m_cyc[1]), .wb2_stb_i(m_stb[1]), .wb2_we_i(m_we[1]), .wb2_sel_i(m_sel[1]),
    .wb2_adr_i(m_adr[1]), .wb2_dat_i(m_dat[1]), .wb2_dat_o(d2), .wb2_ack_o(a2), .wb2_err_o(e2),
    .wb3_cyc_i(m_cyc[2]), .wb3_stb_i(m_stb[2]), .wb3_we_i(m_we[2]), .wb3_sel_i(m_sel[2]),
    .wb3_adr_i(m_adr[2]), .wb3_dat_i(m_dat[2]), .wb3_dat_o(d3), .wb3_ack_o(a3), .wb3_err_o(e3),
    .wb4_cyc_i(m_cyc[3]), .wb4_stb_i(m_stb[3]), .wb4_we_i(m_we[3]), .wb4_sel_i(m_sel[3]),
    .wb4_adr_i(m_adr[3]), .wb4_dat_i(m_dat[3]), .wb4_dat_o(d4), .wb4_ack_o(a4), .wb4_err_o(e4),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we), .wbs_sel_o(s_sel),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack_i),
    .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    s_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sel[i] = '0;
      m_adr[i] = '0;
      m_dat[i] = '0;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle_all();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_g;
    rst_n   = 1'b0;
    idle_all();
    m_cyc   = 4'hF;
    m_stb   = 4'hF;
    s_ack_i = 1'b1;
    tick();
    tick();
    tick();
    n_vec++;
    if ({grant, s_cyc, s_stb, ack_v, err_v} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: grant=%b cyc=%b stb=%b ack=%b err=%b, want all 0",
               grant, s_cyc, s_stb, ack_v, err_v);
    end
    s_ack_i = 1'b0;
    exp_q.push_back(4'b0001);
    rst_n = 1'b1;
    tick();
    exp_g = exp_q.pop_front();
    n_vec++;
    if (grant !== exp_g) begin
      n_bad++;
      $display("FAIL reset_first_grant: grant=%b want %b", grant, exp_g);
    end
    n_vec++;
    if (s_cyc !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_cyc: wbs_cyc_o=%b want 1", s_cyc);
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] g, prev, cur_exp;
    int acks, gap, tenures;
    reset_dut();
    exp_q = {};
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    m_cyc = 4'hF;
    m_stb = 4'hF;
    prev = '0; cur_exp = '0; acks = 0; gap = 0; tenures = 0;
    for (int c = 0; c < 60 && tenures < 5; c++) begin
      tick();
      g = grant;
      if (g == 4'b0) begin
        gap++;
        s_ack_i = 1'b0;
        m_cyc   = 4'hF;
        m_stb   = 4'hF;
      end else begin
        if (prev == 4'b0) begin
          tenures++;
          acks    = 0;
          cur_exp = 4'bx;
          if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
          n_vec++;
          if (g !== cur_exp) begin
            n_bad++;
            $display("FAIL rotation_grant_%0d: grant=%b want %b", tenures, g, cur_exp);
          end
          if (tenures > 1) begin
            n_vec++;
            if (gap !== 1) begin
              n_bad++;
              $display("FAIL rotation_dead_cycles_%0d: got %0d want 1", tenures, gap);
            end
          end
          gap = 0;
        end
        if (acks == 2) begin
          m_cyc   = 4'hF & ~g;
          m_stb   = 4'hF & ~g;
          s_ack_i = 1'b0;
        end else begin
          m_cyc   = 4'hF;
          m_stb   = 4'hF;
          s_ack_i = 1'b1;
          #1;
          n_vec++;
          if (ack_v !== cur_exp) begin
            n_bad++;
            $display("FAIL rotation_ack_%0d: ack=%b want %b", tenures, ack_v, cur_exp);
          end
          acks++;
        end
      end
      prev = g;
    end
    if (tenures < 5) begin
      n_vec++;
      n_bad++;
      $display("FAIL rotation_timeout: %0d tenures seen, want 5", tenures);
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_routing();
    logic [3:0] exp_g;
    idle_all();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    m_adr[2] = 32'h0000_0010; m_dat[2] = 32'hA5A5_A5A5; m_sel[2] = 4'b0011;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    tick();
    exp_g = exp_q.pop_front();
    n_vec++;
    if (grant !== exp_g) begin
      n_bad++;
      $display("FAIL routing_grant3: grant=%b want %b", grant, exp_g);
    end
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
    m_adr[1] = 32'hDEAD_0000; m_dat[1] = 32'h1111_2222; m_sel[1] = 4'b1100;
    s_dat_i = 32'h1234_5678;
    s_ack_i = 1'b1;
    #1;
    n_vec++;
    if ({s_adr, s_sel, s_dat_o, s_we, s_stb} !== {32'h10, 4'b0011, 32'hA5A5_A5A5, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL routing_slave_bus: adr=%h sel=%b dat=%h we=%b stb=%b want 10/0011/a5a5a5a5/1/1",
               s_adr, s_sel, s_dat_o, s_we, s_stb);
    end
    n_vec++;
    if (ack_v !== 4'b0100) begin
      n_bad++;
      $display("FAIL routing_ack: ack=%b want 0100", ack_v);
    end
    n_vec++;
    if ({d1, d2, d3, d4} !== {4{32'h1234_5678}}) begin
      n_bad++;
      $display("FAIL routing_read_data: %h %h %h %h want 12345678", d1, d2, d3, d4);
    end
    tick();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    s_ack_i  = 1'b0;
    tick();
    tick();
    exp_g = exp_q.pop_front();
    n_vec++;
    if ({grant, s_adr, s_sel} !== {exp_g, 32'hDEAD_0000, 4'b1100}) begin
      n_bad++;
      $display("FAIL routing_grant2: grant=%b adr=%h sel=%b want %b/dead0000/1100",
               grant, s_adr, s_sel, exp_g);
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    logic [3:0] exp_e;
    idle_all();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    for (int i = 1; i <= 8; i++) exp_q.push_back((i == 5) ? 4'b0010 : 4'b0000);
    tick();
    n_vec++;
    if (grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL watchdog_grant: grant=%b want 0010", grant);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      s_ack_i = (i == 6);
      if (i == 8) begin
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      end
      #1;
      exp_e = exp_q.pop_front();
      n_vec++;
      if (err_v !== exp_e) begin
        n_bad++;
        $display("FAIL watchdog_err_c%0d: err=%b want %b", i, err_v, exp_e);
      end
      n_vec++;
      if (i >= 5) begin
        if ({s_cyc, s_stb, ack_v} !== 6'd0) begin
          n_bad++;
          $display("FAIL watchdog_abort_c%0d: cyc=%b stb=%b ack=%b want 0", i, s_cyc, s_stb, ack_v);
        end
      end else if (s_cyc !== 1'b1) begin
        n_bad++;
        $display("FAIL watchdog_busy_c%0d: wbs_cyc_o=%b want 1", i, s_cyc);
      end
    end
    s_ack_i = 1'b0;
    tick();
    n_vec++;
    if ({grant, s_cyc} !== 5'd0) begin
      n_bad++;
      $display("FAIL watchdog_idle: grant=%b cyc=%b want 0", grant, s_cyc);
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    idle_all();
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    tick();
    n_vec++;
    if ({grant, s_cyc} !== {4'b1000, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_busy: grant=%b cyc=%b want 1000/1", grant, s_cyc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({grant, s_cyc, err_v} !== 9'd0) begin
      n_bad++;
      $display("FAIL midrst_async: grant=%b cyc=%b err=%b want 0", grant, s_cyc, err_v);
    end
    m_cyc = 4'hF;
    m_stb = 4'hF;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL midrst_first_grant: grant=%b want 0001", grant);
    end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_ack_drop();
    idle_all();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    n_vec++;
    if (grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL ackdrop_grant1: grant=%b want 0001", grant);
    end
    tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    s_ack_i  = 1'b1;
    #1;
    n_vec++;
    if ({ack_v, s_cyc} !== {4'b0001, 1'b0}) begin
      n_bad++;
      $display("FAIL ackdrop_same_cycle: ack=%b cyc=%b want 0001/0", ack_v, s_cyc);
    end
    tick();
    n_vec++;
    if ({grant, ack_v} !== 8'd0) begin
      n_bad++;
      $display("FAIL ackdrop_idle: grant=%b ack=%b want 0/0", grant, ack_v);
    end
    s_ack_i = 1'b0;
    tick();
    n_vec++;
    if ({grant, ack_v} !== {4'b0100, 4'b0000}) begin
      n_bad++;
      $display("FAIL ackdrop_next_owner: grant=%b ack=%b want 0100/0000", grant, ack_v);
    end
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    s_dat_i = '0;
    s_ack_i = 1'b0;
    rst_n   = 1'b0;
    idle_all();
    test_reset();
    test_rotation();
    test_routing();
    test_watchdog();
    test_reset_mid();
    test_ack_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Four-master to one-slave Wishbone arbiter with round-robin fairness, per-cycle bus locking and a stalled-slave watchdog. It shares one slave port, such as the 8 KB blockram's secondary port or a register bank, among up to four bus masters, for example DMA, SPI, CPU bridge and debug. The owner keeps the bus for the whole of its `cyc` assertion. A hung slave is aborted with `err` instead of locking up the bus.

## Interface
Parameters:
- `TIMEOUT`, default 255: slave-wait cycles allowed before abort; legal range 1..255; counter is 8 bits.
- `FIRST_PRIO`, default 1: master favoured first after reset; legal values 1..4.

Ports (N = 1..4):
- `wb_clk_i`  in  1  sole clock; all logic rises on its positive edge.
- `wb_rst_n_i`  in  1  reset; asynchronous, active-low.
- `wbN_cyc_i`  in  1  master N cycle request and bus lock.
- `wbN_stb_i`  in  1  master N strobe.
- `wbN_we_i`  in  1  master N write enable.
- `wbN_sel_i`  in  4  master N byte selects.
- `wbN_adr_i`  in  32  master N address.
- `wbN_dat_i`  in  32  master N write data.
- `wbN_dat_o`  out  32  read data; equals `wbs_dat_i` for every master.
- `wbN_ack_o`  out  1  slave ack, routed to the owner only.
- `wbN_err_o`  out  1  watchdog abort, owner only, 1-cycle pulse.
- `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o`  out  1 each  slave controls.
- `wbs_sel_o`  out  4  slave byte selects.
- `wbs_adr_o`  out  32  slave address.
- `wbs_dat_o`  out  32  slave write data.
- `wbs_dat_i`  in  32  slave read data.
- `wbs_ack_i`  in  1  slave ack.
- `grant_o`  out  4  one-hot current owner; 0 when the bus is free.

## Operation
States: IDLE, BUSY, ABORT.
- **IDLE**
  - No owner. All `wbs_*` outputs are 0.
  - If any `wbN_cyc_i` is high, pick the first requester at or after `last+1`, wrapping 4 to 1. Register it as `owner`, set `last`, and go to BUSY.
- **BUSY**
  - The owner's `cyc`, `stb`, `we`, `sel`, `adr` and `dat` drive `wbs_*` combinationally from the registered owner.
  - `wbs_ack_i` appears on the owner's `ack_o` combinationally. Non-owners see `ack_o` = 0 and `err_o` = 0.
  - Owner `cyc` low: go to IDLE. `wbs_cyc_o` drops in the same cycle because it is a pass-through.
  - Watchdog:
    - The counter clears when the owner's `stb` is low or `wbs_ack_i` is 1.
    - Otherwise it increments while owner `stb` is high.
    - When it reaches `TIMEOUT`, go to ABORT.
- **ABORT**
  - `wbs_cyc_o` and `wbs_stb_o` are forced to 0.
  - The owner's `err_o` is high for the first ABORT cycle only.
  - Stay in ABORT until owner `cyc` goes low, then go to IDLE.
  - `wbs_ack_i` is ignored in ABORT.
- **Simultaneous requests:** resolved only by the rotation; there is no fixed priority.
- **Starvation bound:** a requester waits at most 3 bus tenures.
- **Ack coinciding with cyc drop:** if `wbs_ack_i` arrives in the same cycle the owner drops `cyc`, it still passes to that owner's `ack_o`. The master is responsible for ignoring it.
- **Inputs gating the slave:** non-owner inputs never reach `wbs_*`.

## Timing
- **Reset values (`wb_rst_n_i` low):**
  - state = IDLE, `last` = `FIRST_PRIO`-1 (with 0 read as 4), counter = 0.
  - Every `ack_o`, `err_o`, `wbs_cyc_o`, `wbs_stb_o` and `grant_o` is 0.
  - Reset asserted mid-transfer drops `wbs_cyc_o` asynchronously, with no abort pulse.
- **Grant latency:** request seen in IDLE at edge k gives `grant_o` and `wbs_cyc_o` valid from edge k+1.
- **Hand-over:** owner drops `cyc` before edge k. IDLE holds for cycle k. The next owner drives the slave from edge k+1, so there is exactly one dead cycle between tenures.
- **Pipelining:** adds zero cycles to slave ack latency; the arbiter inserts no wait states inside a tenure.
- **Abort timing:** with `stb` held and no ack, `err_o` pulses `TIMEOUT`+1 cycles after the first `stb` cycle.

## Structure
- **Package `wb_arb_pkg`:**
  - State encoding: IDLE=2'd0, BUSY=2'd1, ABORT=2'd2.
  - `NMASTERS` = 4 and owner ID width = 2.
  - Counter width = 8.
- **Sub-module `rr_priority_pick`:** combinational. Takes a 4-bit request vector and the 2-bit last ID, and returns a one-hot grant plus its ID. It is reused by other arbiters.
- **Top level:** FSM, watchdog counter, output muxes.

## Test plan
- **Reset:** all `cyc` high during reset → all outputs 0. Release reset → master 1 granted at the next edge, `grant_o` = 4'b0001.
- **Fair rotation:** masters 1–4 request continuously, each owner holding for 2 acks → grant order 1,2,3,4,1, with one dead cycle between tenures.
- **Routing:** master 3 writes `adr` 0x10, `dat` 0xA5A5A5A5, `sel` 4'b0011, while master 2 drives a different address → `wbs_adr_o` = 0x10, `wbs_sel_o` = 4'b0011, only `wb3_ack_o` pulses.
- **Watchdog:** `TIMEOUT` = 4, slave never acks → `wb2_err_o` is high for 1 cycle, 5 cycles after `stb`. `wbs_cyc_o` = 0 while in ABORT. IDLE is entered after master 2 drops `cyc`.
- **Reset mid-transfer:** assert reset while master 4 is in BUSY → `wbs_cyc_o` goes to 0 without waiting for a clock. After release, the first grant goes to master 1.
- **Ack with cyc drop:** `wbs_ack_i` arrives in the same cycle master 1 drops `cyc` → `wb1_ack_o` = 1 in that cycle, the arbiter is in IDLE next, and there is no spurious ack to the next owner.
